// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and parameter defaults for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } arb_owner_t;

   localparam int unsigned LAT_DEFAULT        = 2;
   localparam int unsigned STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/arb_prio_pick.sv
// Winner selection: data port has priority unless fetch has been starved STARVE_MAX times.
module arb_prio_pick
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic       i_if_valid,
   input  logic       i_dm_valid,
   input  logic [2:0] i_streak,
   output logic       o_pick_if,
   output logic       o_pick_dm
);

   always_comb begin
      o_pick_if = i_if_valid && (!i_dm_valid || (i_streak == 3'(STARVE_MAX)));
      o_pick_dm = i_dm_valid && !o_pick_if;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one fixed-latency memory port between fetch and data.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned LAT        = LAT_DEFAULT,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_if_req_valid,
   input  logic [31:0] i_if_addr,
   output logic        o_if_req_ready,
   input  logic        i_if_flush,
   output logic        o_if_rsp_valid,
   output logic [31:0] o_if_rsp_data,
   input  logic        i_dm_req_valid,
   input  logic        i_dm_we,
   input  logic [31:0] i_dm_addr,
   input  logic [31:0] i_dm_wdata,
   output logic        o_dm_req_ready,
   output logic        o_dm_rsp_valid,
   output logic [31:0] o_dm_rsp_data,
   output logic        o_mem_en,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata,
   output logic        o_stall_if,
   output logic        o_stall_mem
);

   arb_state_t  r_state;
   arb_owner_t  r_owner;
   logic        r_we;
   logic        r_drop;
   logic [2:0]  r_cnt;
   logic [2:0]  r_streak;
   logic [31:0] r_if_data;
   logic [31:0] r_dm_data;

   logic        w_pick_if;
   logic        w_pick_dm;
   logic        w_idle;
   logic        w_done;
   logic        w_if_rsp;
   logic        w_dm_rsp;
   logic [31:0] w_dm_data;

   arb_prio_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
      .i_if_valid (i_if_req_valid),
      .i_dm_valid (i_dm_req_valid),
      .i_streak   (r_streak),
      .o_pick_if  (w_pick_if),
      .o_pick_dm  (w_pick_dm)
   );

   // Reset gates the combinational handshake so strobes drop the instant reset asserts.
   always_comb begin
      w_idle         = (r_state == ST_IDLE) && i_rst_n;
      o_if_req_ready = w_idle && w_pick_if;
      o_dm_req_ready = w_idle && w_pick_dm;
      o_mem_en       = o_if_req_ready || o_dm_req_ready;
      o_mem_we       = o_dm_req_ready && i_dm_we;
      o_mem_addr     = o_dm_req_ready ? i_dm_addr :
                       (o_if_req_ready ? i_if_addr : '0);
      o_mem_wdata    = o_dm_req_ready ? i_dm_wdata : '0;
      o_stall_if     = i_if_req_valid && !o_if_req_ready;
      o_stall_mem    = i_dm_req_valid && !o_dm_req_ready;

      w_done         = (r_state == ST_BUSY) && (r_cnt == 3'(LAT));
      w_if_rsp       = w_done && (r_owner == OWN_IF) && !r_drop && !i_if_flush;
      w_dm_rsp       = w_done && (r_owner == OWN_DM);
      w_dm_data      = r_we ? '0 : i_mem_rdata;

      o_if_rsp_valid = w_if_rsp;
      o_dm_rsp_valid = w_dm_rsp;
      o_if_rsp_data  = w_if_rsp ? i_mem_rdata : r_if_data;
      o_dm_rsp_data  = w_dm_rsp ? w_dm_data : r_dm_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_owner   <= OWN_IF;
         r_we      <= 1'b0;
         r_drop    <= 1'b0;
         r_cnt     <= '0;
         r_streak  <= '0;
         r_if_data <= '0;
         r_dm_data <= '0;
      end else begin
         if (!i_if_req_valid || o_if_req_ready)
            r_streak <= '0;
         else if (o_dm_req_ready && (r_streak != 3'd7))
            r_streak <= r_streak + 3'd1;

         case (r_state)
            ST_IDLE: begin
               if (o_mem_en) begin
                  r_state <= ST_BUSY;
                  r_owner <= o_dm_req_ready ? OWN_DM : OWN_IF;
                  r_we    <= o_mem_we;
                  r_cnt   <= 3'd1;
                  r_drop  <= 1'b0;
               end
            end
            ST_BUSY: begin
               if ((r_owner == OWN_IF) && i_if_flush)
                  r_drop <= 1'b1;
               if (w_done) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
                  r_drop  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
               if (w_if_rsp)
                  r_if_data <= i_mem_rdata;
               if (w_dm_rsp)
                  r_dm_data <= w_dm_data;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table-driven bench for mem_port_arbiter at LAT=2, STARVE_MAX=4.
module tb_mem_port_arbiter;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_if_req_valid;
   logic [31:0] i_if_addr;
   logic        o_if_req_ready;
   logic        i_if_flush;
   logic        o_if_rsp_valid;
   logic [31:0] o_if_rsp_data;
   logic        i_dm_req_valid;
   logic        i_dm_we;
   logic [31:0] i_dm_addr;
   logic [31:0] i_dm_wdata;
   logic        o_dm_req_ready;
   logic        o_dm_rsp_valid;
   logic [31:0] o_dm_rsp_data;
   logic        o_mem_en;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [31:0] i_mem_rdata;
   logic        o_stall_if;
   logic        o_stall_mem;

   int unsigned checks;
   int unsigned failures;

   mem_port_arbiter #(.LAT(2), .STARVE_MAX(4)) dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_if_req_valid (i_if_req_valid),
      .i_if_addr      (i_if_addr),
      .o_if_req_ready (o_if_req_ready),
      .i_if_flush     (i_if_flush),
      .o_if_rsp_valid (o_if_rsp_valid),
      .o_if_rsp_data  (o_if_rsp_data),
      .i_dm_req_valid (i_dm_req_valid),
      .i_dm_we        (i_dm_we),
      .i_dm_addr      (i_dm_addr),
      .i_dm_wdata     (i_dm_wdata),
      .o_dm_req_ready (o_dm_req_ready),
      .o_dm_rsp_valid (o_dm_rsp_valid),
      .o_dm_rsp_data  (o_dm_rsp_data),
      .o_mem_en       (o_mem_en),
      .o_mem_we       (o_mem_we),
      .o_mem_addr     (o_mem_addr),
      .o_mem_wdata    (o_mem_wdata),
      .i_mem_rdata    (i_mem_rdata),
      .o_stall_if     (o_stall_if),
      .o_stall_mem    (o_stall_mem)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // Flag order: if_rdy, dm_rdy, mem_en, mem_we, if_rsp_v, dm_rsp_v, stall_if, stall_mem.
   typedef struct {
      logic        iv;
      logic [31:0] ia;
      logic        fl;
      logic        dv;
      logic        we;
      logic [31:0] da;
      logic [31:0] wd;
      logic [31:0] rd;
      logic [7:0]  e_flags;
      logic [31:0] e_maddr;
      logic [31:0] e_mwd;
      logic [31:0] e_ifd;
      logic [31:0] e_dmd;
   } vec_t;

   localparam int NV = 31;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic iv, input logic [31:0] ia, input logic fl,
                               input logic dv, input logic we, input logic [31:0] da,
                               input logic [31:0] wd, input logic [31:0] rd,
                               input logic [7:0] ef, input logic [31:0] ema,
                               input logic [31:0] emw, input logic [31:0] eif,
                               input logic [31:0] edm);
      vec_t v;
      v.iv = iv; v.ia = ia; v.fl = fl; v.dv = dv; v.we = we; v.da = da; v.wd = wd; v.rd = rd;
      v.e_flags = ef; v.e_maddr = ema; v.e_mwd = emw; v.e_ifd = eif; v.e_dmd = edm;
      return v;
   endfunction

   function automatic logic [7:0] flags();
      return {o_if_req_ready, o_dm_req_ready, o_mem_en, o_mem_we,
              o_if_rsp_valid, o_dm_rsp_valid, o_stall_if, o_stall_mem};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [31:0] ia, input logic fl, input logic dv,
                        input logic we, input logic [31:0] da, input logic [31:0] wd,
                        input logic [31:0] rd);
      i_if_req_valid = iv; i_if_addr = ia; i_if_flush = fl;
      i_dm_req_valid = dv; i_dm_we = we; i_dm_addr = da; i_dm_wdata = wd; i_mem_rdata = rd;
   endtask

   initial begin
      logic [5:0] gseq;
      int         gcyc [6];
      int         n;

      checks   = 0;
      failures = 0;
      gseq     = '0;
      n        = 0;
      for (int k = 0; k < 6; k++) gcyc[k] = -1;

      //          iv ia        fl dv we da          wd           rd            flags  maddr        mwd          ifd          dmd
      tbl[0]  = mk(1, 32'h100, 0, 0, 0, 32'h0,      32'h0,       32'h0,        8'hA0, 32'h100,     32'h0,       32'h0,       32'h0);
      tbl[1]  = mk(0, 32'h0,   0, 0, 0, 32'h0,      32'h0,       32'h0,        8'h00, 32'h0,       32'h0,       32'h0,       32'h0);
      tbl[2]  = mk(0, 32'h0,   0, 0, 0, 32'h0,      32'h0,       32'h00500093, 8'h08, 32'h0,       32'h0,       32'h00500093,32'h0);
      tbl[3]  = mk(0, 32'h0,   0, 0, 0, 32'h0,      32'h0,       32'h0,        8'h00, 32'h0,       32'h0,       32'h00500093,32'h0);
      tbl[4]  = mk(1, 32'h104, 0, 1, 0, 32'h2000,   32'h0,       32'h0,        8'h62, 32'h2000,    32'h0,       32'h00500093,32'h0);
      tbl[5]  = mk(1, 32'h104, 0, 0, 0, 32'h0,      32'h0,       32'h0,        8'h02, 32'h0,       32'h0,       32'h00500093,32'h0);
      tbl[6]  = mk(1, 32'h104, 0, 0, 0, 32'h0,      32'h0,       32'h11112222, 8'h06, 32'h0,       32'h0,       32'h00500093,32'h11112222);
      tbl[7]  = mk(1, 32'h104, 0, 0, 0, 32'h0,      32'h0,       32'h0,        8'hA0, 32'h104,     32'h0,       32'h00500093,32'h11112222);
      tbl[8]  = mk(0, 32'h0,   0, 0, 0, 32'h0,      32'h0,       32'h0,        8'h00, 32'h0,       32'h0,       32'h00500093,32'h11112222);
      tbl[9]  = mk(0, 32'h0,   0, 0, 0, 32'h0,      32'h0,       32'h33334444, 8'h08, 32'h0,       32'h0,       32'h33334444,32'h11112222);
      tbl[10] = mk(0, 32'h0,   0, 1, 1, 32'h2004,   32'hDEADBEEF,32'h0,        8'h70, 32'h2004,    32'hDEADBEEF,32'h33334444,32'h11112222);
      tbl[11] = mk(0, 32'h0,   0, 0, 0, 32'h0,      32'h0,       32'h0,        8'h00, 32'h0,       32'h0,       32'h33334444,32'h11112222);
      tbl[12] = mk(0, 32'h0,   0, 0, 0, 32'h0,      32'h0,       32'h55555555, 8'h04, 32'h0,       32'h0,       32'h33334444,32'h0);
      tbl[13] = mk(0, 32'h0,   0, 1, 0, 32'h3000,   32'h0,       32'h0,        8'h60, 32'h3000,    32'h0,       32'h33334444,32'h0);
      tbl[14] = mk(0, 32'h0,   0, 1, 0, 32'h3000,   32'h0,       32'h0,        8'h01, 32'h0,       32'h0,       32'h33334444,32'h0);
      tbl[15] = mk(0, 32'h0,   0, 1, 0, 32'h3000,   32'h0,       32'h77,       8'h05, 32'h0,       32'h0,       32'h33334444,32'h77);
      tbl[16] = mk(0, 32'h0,   1, 1, 0, 32'h3004,   32'h0,       32'h0,        8'h60, 32'h3004,    32'h0,       32'h33334444,32'h77);
      tbl[17] = mk(0, 32'h0,   1, 0, 0, 32'h0,      32'h0,       32'h0,        8'h00, 32'h0,       32'h0,       32'h33334444,32'h77);
      tbl[18] = mk(0, 32'h0,   0, 0, 0, 32'h0,      32'h0,       32'h88,       8'h04, 32'h0,       32'h0,       32'h33334444,32'h88);
      tbl[19] = mk(1, 32'h200, 1, 0, 0, 32'h0,      32'h0,       32'h0,        8'hA0, 32'h200,     32'h0,       32'h33334444,32'h88);
      tbl[20] = mk(0, 32'h0,   0, 0, 0, 32'h0,      32'h0,       32'h0,        8'h00, 32'h0,       32'h0,       32'h33334444,32'h88);
      tbl[21] = mk(0, 32'h0,   0, 0, 0, 32'h0,      32'h0,       32'h99,       8'h08, 32'h0,       32'h0,       32'h99,      32'h88);
      tbl[22] = mk(1, 32'h300, 0, 0, 0, 32'h0,      32'h0,       32'h0,        8'hA0, 32'h300,     32'h0,       32'h99,      32'h88);
      tbl[23] = mk(0, 32'h0,   0, 0, 0, 32'h0,      32'h0,       32'h0,        8'h00, 32'h0,       32'h0,       32'h99,      32'h88);
      tbl[24] = mk(0, 32'h0,   1, 0, 0, 32'h0,      32'h0,       32'hAA,       8'h00, 32'h0,       32'h0,       32'h99,      32'h88);
      tbl[25] = mk(1, 32'h304, 0, 0, 0, 32'h0,      32'h0,       32'h0,        8'hA0, 32'h304,     32'h0,       32'h99,      32'h88);
      tbl[26] = mk(0, 32'h0,   1, 0, 0, 32'h0,      32'h0,       32'h0,        8'h00, 32'h0,       32'h0,       32'h99,      32'h88);
      tbl[27] = mk(0, 32'h0,   0, 0, 0, 32'h0,      32'h0,       32'hBB,       8'h00, 32'h0,       32'h0,       32'h99,      32'h88);
      tbl[28] = mk(1, 32'h308, 0, 0, 0, 32'h0,      32'h0,       32'h0,        8'hA0, 32'h308,     32'h0,       32'h99,      32'h88);
      tbl[29] = mk(0, 32'h0,   0, 0, 0, 32'h0,      32'h0,       32'h0,        8'h00, 32'h0,       32'h0,       32'h99,      32'h88);
      tbl[30] = mk(0, 32'h0,   0, 0, 0, 32'h0,      32'h0,       32'hCC,       8'h08, 32'h0,       32'h0,       32'hCC,      32'h88);

      // Reset state, with a fetch request pending to show readies are held off.
      i_rst_n = 1'b0;
      drive(1, 32'h100, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      #1;
      chk("reset_flags", 32'(flags()), 32'h02);
      chk("reset_maddr", o_mem_addr, 32'h0);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      drive(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);

      for (int i = 0; i < NV; i++) begin
         @(negedge i_clk);
         drive(tbl[i].iv, tbl[i].ia, tbl[i].fl, tbl[i].dv, tbl[i].we, tbl[i].da, tbl[i].wd, tbl[i].rd);
         #1;
         chk($sformatf("row%0d_flags", i), 32'(flags()), 32'(tbl[i].e_flags));
         chk($sformatf("row%0d_maddr", i), o_mem_addr,    tbl[i].e_maddr);
         chk($sformatf("row%0d_mwdata", i), o_mem_wdata,  tbl[i].e_mwd);
         chk($sformatf("row%0d_ifdata", i), o_if_rsp_data, tbl[i].e_ifd);
         chk($sformatf("row%0d_dmdata", i), o_dm_rsp_data, tbl[i].e_dmd);
      end

      // Starvation: both requesters held; expect DM x4, IF, DM at 3-cycle spacing.
      for (int c = 0; c < 40 && n < 6; c++) begin
         @(negedge i_clk);
         if (c == 0) drive(1, 32'h400, 0, 1, 0, 32'h5000, 32'h0, 32'h0);
         #1;
         if (o_dm_req_ready) begin
            gseq[n] = 1'b1; gcyc[n] = c; n++;
         end else if (o_if_req_ready) begin
            gseq[n] = 1'b0; gcyc[n] = c; n++;
         end
      end
      chk("starve_grant_count", 32'(n), 32'd6);
      chk("starve_grant_order", 32'(gseq), 32'b101111);
      chk("starve_if_grant_cycle", 32'(gcyc[4]), 32'd12);
      chk("starve_dm_resume_cycle", 32'(gcyc[5]), 32'd15);
      @(negedge i_clk);
      drive(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      repeat (3) @(negedge i_clk);

      // Reset in the middle of a DM load.
      drive(0, 32'h0, 0, 1, 0, 32'h2000, 32'h0, 32'h0);
      #1;
      chk("rst_dm_grant", 32'(o_dm_req_ready), 32'd1);
      @(negedge i_clk);
      drive(1, 32'h100, 0, 1, 0, 32'h2000, 32'h0, 32'h0);
      i_rst_n = 1'b0;
      #1;
      chk("rst_mid_flags", 32'(flags()), 32'h03);
      chk("rst_mid_maddr", o_mem_addr, 32'h0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      drive(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h5A5A5A5A);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("rst_no_rsp%0d", k), 32'(flags()), 32'h00);
         @(negedge i_clk);
      end
      drive(1, 32'h600, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      #1;
      chk("post_rst_if_grant", 32'(flags()), 32'hA0);
      chk("post_rst_if_maddr", o_mem_addr, 32'h600);
      @(negedge i_clk);
      drive(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      #1;
      chk("post_rst_busy", 32'(flags()), 32'h00);
      @(negedge i_clk);
      i_mem_rdata = 32'h1234;
      #1;
      chk("post_rst_if_rsp", 32'(flags()), 32'h08);
      chk("post_rst_if_data", o_if_rsp_data, 32'h1234);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter LAT, default 2: fixed memory read/write latency in cycles, legal range 1..4.
REQ-002 Parameter STARVE_MAX, default 4: maximum consecutive data grants while fetch waits.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 if_req_valid  input  1  fetch requests an instruction read.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_req_ready  output  1  fetch request accepted this cycle.
REQ-008 if_flush  input  1  discard outstanding fetch response (branch taken).
REQ-009 if_rsp_valid  output  1  one-cycle pulse, instruction valid.
REQ-010 if_rsp_data  output  32  instruction word.
REQ-011 dm_req_valid  input  1  data stage requests access.
REQ-012 dm_we  input  1  1 = store, 0 = load.
REQ-013 dm_addr  input  32  data byte address.
REQ-014 dm_wdata  input  32  store data.
REQ-015 dm_req_ready  output  1  data request accepted this cycle.
REQ-016 dm_rsp_valid  output  1  one-cycle pulse, load data valid or store complete.
REQ-017 dm_rsp_data  output  32  load data; 0 for stores.
REQ-018 mem_en  output  1  memory access strobe.
REQ-019 mem_we  output  1  memory write enable.
REQ-020 mem_addr  output  32  memory address.
REQ-021 mem_wdata  output  32  memory write data.
REQ-022 mem_rdata  input  32  memory read data, valid exactly LAT cycles after mem_en.
REQ-023 stall_if, stall_mem  output  1 each  = req_valid AND NOT req_ready, per requester, for the hazard unit.

Function
REQ-024 FSM states: IDLE, BUSY; one transaction outstanding at most.
REQ-025 IDLE: winner is DM if dm_req_valid, else IF if if_req_valid; exception: IF wins when if_req_valid and streak == STARVE_MAX.
REQ-026 Winner's ready is asserted combinationally in IDLE only; the loser's ready and both readies in BUSY are 0.
REQ-027 On handshake: mem_en = 1, mem_we = dm_we (0 for IF), and mem_addr/mem_wdata are driven combinationally from the winner; register owner, we and cnt = 1; go to BUSY.
REQ-028 Outside a handshake cycle, mem_en = mem_we = 0 and mem_addr/mem_wdata = 0.
REQ-029 BUSY: cnt increments each cycle; when cnt == LAT, sample mem_rdata, pulse the owner's rsp_valid and go to IDLE; no grant is made in that cycle.
REQ-030 Latency from handshake to response is LAT cycles; peak throughput is one transaction per LAT+1 cycles.
REQ-031 streak (3 bits, saturating): increments on a DM grant while if_req_valid = 1; clears on an IF grant or whenever if_req_valid = 0.
REQ-032 Store response: dm_rsp_valid pulses with dm_rsp_data = 0.
REQ-033 if_flush high in any cycle while an IF transaction is outstanding (including the response cycle) sets a drop flag; the response is suppressed but the FSM still waits for LAT.
REQ-034 if_flush during IDLE or during a DM transaction has no effect.
REQ-035 Simultaneous if_flush and a new IF handshake: the new request is kept, not dropped.
REQ-036 Response data outputs hold their last value between pulses.

Reset
REQ-037 rst low: state = IDLE, cnt = 0, streak = 0, drop = 0, owner = IF, and all rsp_valid, mem_en and mem_we = 0 immediately.
REQ-038 Reset mid-transaction abandons it; no response is ever issued for it.

Structure
REQ-039 The shared package holds the state encoding (IDLE = 0, BUSY = 1), owner encoding (IF = 0, DM = 1), and LAT/STARVE_MAX defaults.
REQ-040 One sub-module: arb_prio_pick (combinational winner selection from the valids and streak).

Verification (LAT = 2, STARVE_MAX = 4)
REQ-041 IF read 0x100 alone, mem_rdata = 0x00500093 -> if_req_ready at cycle 0, if_rsp_valid at cycle 2 with 0x00500093.
REQ-042 IF and DM load 0x2000 asserted together -> DM granted first and stall_if = 1; IF granted at cycle 3, its response at cycle 5.
REQ-043 DM store 0x2004 = 0xDEADBEEF -> mem_we = 1, mem_wdata = 0xDEADBEEF at grant; dm_rsp_valid at +2 with data 0.
REQ-044 DM held valid for 5 requests while IF waits -> 4 DM grants, then IF grant, then DM resumes.
REQ-045 IF grant then if_flush at +1 -> no if_rsp_valid; next grant possible at +3.
REQ-046 rst low at +1 after a DM load grant -> all outputs 0 at once; no dm_rsp_valid after release; a fresh IF read completes normally.
